// File: rtl/hram_cmd_seq.sv
// ============================================================================
// Module      : hram_cmd_seq
// Description : HyperRAM command sequencer. Holds off for power-up, accepts
//               one request at a time, builds the CA word, starts the matching
//               engine and waits for its completion.
//               Optional WAIT watchdog compiled in with `define HRAM_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hram_cmd_seq #(
    parameter int PWRUP_CYCLES   = 15000,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic        req_linear,
    output logic [47:0] casig,
    output logic        start_rdreg,
    output logic        start_wrreg,
    output logic        start_rdmem,
    output logic        start_wrmem,
    input  logic        end_rdreg,
    input  logic        end_wrreg,
    input  logic        end_rdmem,
    input  logic        end_wrmem,
    output logic        busy,
    output logic        done,
    output logic        err_timeout
);

    localparam int PWR_W = $clog2(PWRUP_CYCLES + 1);

    localparam logic [1:0] c_OP_RDREG = 2'b00;
    localparam logic [1:0] c_OP_WRREG = 2'b01;
    localparam logic [1:0] c_OP_RDMEM = 2'b10;
    localparam logic [1:0] c_OP_WRMEM = 2'b11;

    typedef enum logic [2:0] {
        S_PWRUP  = 3'd0,
        S_IDLE   = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    if (PWRUP_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("hram_cmd_seq: PWRUP_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [PWR_W-1:0]  r_pwr_cnt;
    logic [1:0]        r_op;
    logic [47:0]       r_casig;
    logic              w_accept;
    logic              w_end_sel;
    logic              w_pwr_last;

    assign w_pwr_last = (r_pwr_cnt == PWR_W'(PWRUP_CYCLES - 1));
    assign w_accept   = (r_state == S_IDLE) && req_valid;
    assign casig      = r_casig;

    // Only the completion line of the latched op can end the WAIT state.
    always_comb begin
        w_end_sel = 1'b0;
        case (r_op)
            c_OP_RDREG: w_end_sel = end_rdreg;
            c_OP_WRREG: w_end_sel = end_wrreg;
            c_OP_RDMEM: w_end_sel = end_rdmem;
            c_OP_WRMEM: w_end_sel = end_wrmem;
            default:    w_end_sel = 1'b0;
        endcase
    end

`ifdef HRAM_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_tmo;
    logic             w_tmo_hit;

    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    // A completion arriving on the same cycle as the limit takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
        end else if (r_state == S_LAUNCH) begin
            r_tmo_cnt <= '0;
            r_tmo     <= 1'b0;
        end else if (r_state == S_WAIT) begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
            r_tmo     <= !w_end_sel && w_tmo_hit;
        end
    end

    assign err_timeout = (r_state == S_RESP) && r_tmo;
`else
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_PWRUP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        start_rdreg = 1'b0;
        start_wrreg = 1'b0;
        start_rdmem = 1'b0;
        start_wrmem = 1'b0;
        case (r_state)
            S_PWRUP: begin
                if (w_pwr_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    w_state_nxt = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                start_rdreg = (r_op == c_OP_RDREG);
                start_wrreg = (r_op == c_OP_WRREG);
                start_rdmem = (r_op == c_OP_RDMEM);
                start_wrmem = (r_op == c_OP_WRMEM);
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (w_end_sel) begin
                    w_state_nxt = S_RESP;
                end
`ifdef HRAM_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_state_nxt = S_RESP;
                end
`endif
            end
            S_RESP: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_PWRUP;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwr_cnt <= '0;
            r_op      <= 2'b00;
            r_casig   <= '0;
        end else begin
            if (r_state == S_PWRUP && !w_pwr_last) begin
                r_pwr_cnt <= r_pwr_cnt + 1'b1;
            end
            if (w_accept) begin
                r_op    <= req_op;
                r_casig <= {!req_op[0], !req_op[1], req_linear,
                            req_addr[31:3], 13'd0, req_addr[2:0]};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_hram_cmd_seq.sv
// ============================================================================
// Module      : tb_hram_cmd_seq
// Description : Directed self-checking bench for hram_cmd_seq
//               (PWRUP_CYCLES=8, TIMEOUT_CYCLES=16).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hram_cmd_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic        req_linear;
    logic [47:0] casig;
    logic        start_rdreg, start_wrreg, start_rdmem, start_wrmem;
    logic        end_rdreg, end_wrreg, end_rdmem, end_wrmem;
    logic        busy, done, err_timeout;
    logic [3:0]  w_starts;

    int          n_checks;
    int          n_errors;

    assign w_starts = {start_wrmem, start_rdmem, start_wrreg, start_rdreg};

    hram_cmd_seq #(
        .PWRUP_CYCLES   (8),
        .TIMEOUT_CYCLES (16)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_linear  (req_linear),
        .casig       (casig),
        .start_rdreg (start_rdreg),
        .start_wrreg (start_wrreg),
        .start_rdmem (start_rdmem),
        .start_wrmem (start_wrmem),
        .end_rdreg   (end_rdreg),
        .end_wrreg   (end_wrreg),
        .end_rdmem   (end_rdmem),
        .end_wrmem   (end_wrmem),
        .busy        (busy),
        .done        (done),
        .err_timeout (err_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pwrup();
        for (int i = 0; i < 8; i++) begin
            chk("pwrup_ready_low", 64'(req_ready), 64'd0);
            chk("pwrup_busy", 64'(busy), 64'd1);
            tick();
        end
        chk("pwrup_ready_high", 64'(req_ready), 64'd1);
        chk("pwrup_busy_low", 64'(busy), 64'd0);
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] addr, input logic lin);
        req_op     = op;
        req_addr   = addr;
        req_linear = lin;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        req_valid  = 1'b1;
        req_op     = 2'b10;
        req_addr   = 32'h0000_1234;
        req_linear = 1'b1;
        end_rdreg  = 1'b0;
        end_wrreg  = 1'b0;
        end_rdmem  = 1'b0;
        end_wrmem  = 1'b0;
        tick();
        tick();

        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        chk("rst_casig", 64'(casig), 64'd0);
        chk("rst_starts", 64'(w_starts), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_err", 64'(err_timeout), 64'd0);

        // Power-up with req_valid held high; first accept is the rdmem request.
        rst = 1'b0;
        check_pwrup();
        tick();
        req_valid = 1'b0;
        chk("rdmem_casig", 64'(casig), 64'hA000_0246_0004);
        chk("rdmem_start", 64'(w_starts), 64'b0100);
        chk("rdmem_ready_low", 64'(req_ready), 64'd0);
        tick();
        chk("rdmem_start_gone", 64'(w_starts), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rdmem_wait_done", 64'(done), 64'd0);
        end
        end_rdmem = 1'b1;
        tick();
        end_rdmem = 1'b0;
        chk("rdmem_done", 64'(done), 64'd1);
        chk("rdmem_err", 64'(err_timeout), 64'd0);
        chk("rdmem_casig_hold", 64'(casig), 64'hA000_0246_0004);
        tick();
        chk("rdmem_done_once", 64'(done), 64'd0);
        chk("rdmem_ready_back", 64'(req_ready), 64'd1);

        // rdreg: end during LAUNCH and foreign end during WAIT are both ignored.
        issue(2'b00, 32'h0, 1'b1);
        chk("rdreg_casig", 64'(casig), 64'hE000_0000_0000);
        chk("rdreg_start", 64'(w_starts), 64'b0001);
        end_rdreg = 1'b1;
        tick();
        end_rdreg = 1'b0;
        end_wrmem = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rdreg_ignored_end", 64'(done), 64'd0);
            chk("rdreg_busy", 64'(busy), 64'd1);
        end
        end_wrmem = 1'b0;
        end_rdreg = 1'b1;
        tick();
        end_rdreg = 1'b0;
        chk("rdreg_done", 64'(done), 64'd1);
        tick();
        chk("rdreg_ready_back", 64'(req_ready), 64'd1);

        // wrmem aborted by reset during WAIT.
        issue(2'b11, 32'h0000_0010, 1'b1);
        chk("wrmem_casig", 64'(casig), 64'h2000_0002_0000);
        chk("wrmem_start", 64'(w_starts), 64'b1000);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_casig", 64'(casig), 64'd0);
        chk("abort_starts", 64'(w_starts), 64'd0);
        chk("abort_err", 64'(err_timeout), 64'd0);
        check_pwrup();

        // wrreg with no completion at all.
        issue(2'b01, 32'h0000_0000, 1'b0);
        chk("wrreg_casig", 64'(casig), 64'h4000_0000_0000);
        chk("wrreg_start", 64'(w_starts), 64'b0010);
        tick();
`ifdef HRAM_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("tmo_early_done", 64'(done), 64'd0);
        end
        tick();
        chk("tmo_done", 64'(done), 64'd1);
        chk("tmo_err", 64'(err_timeout), 64'd1);
        tick();
        chk("tmo_done_clear", 64'(done), 64'd0);
        chk("tmo_err_clear", 64'(err_timeout), 64'd0);
        chk("tmo_ready", 64'(req_ready), 64'd1);
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("notmo_done", 64'(done), 64'd0);
            chk("notmo_busy", 64'(busy), 64'd1);
            chk("notmo_err", 64'(err_timeout), 64'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
